// File: rtl/regfile_tagged.sv
// Tagged register file for a dynamic-pipeline core: NRD bypassing read ports,
// a per-register busy/tag scoreboard, tag-qualified CDB writeback, flush and a busy counter.
module regfile_tagged #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TAG_W  = 4,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD-1:0]        rena,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    output logic [NRD*TAG_W-1:0]  rtag,
    input  logic                  alloc_valid,
    input  logic [ADDR_W-1:0]     alloc_addr,
    input  logic [TAG_W-1:0]      alloc_tag,
    input  logic                  wb_valid,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [TAG_W-1:0]      wb_tag,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     dbg_addr,
    output logic [DATA_W-1:0]     dbg_data,
    output logic [ADDR_W:0]       busy_cnt
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] data_q [NREGS];
    logic [DATA_W-1:0] data_d [NREGS];
    logic [TAG_W-1:0]  tag_q  [NREGS];
    logic [TAG_W-1:0]  tag_d  [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;

    logic              wb_hit_s;
    logic              alloc_hit_s;
    logic [NREGS-1:0]  wb_sel_s;
    logic [NREGS-1:0]  al_sel_s;
    logic [ADDR_W-1:0] raddr_s [NRD];

    function automatic logic [ADDR_W:0] popcount(input logic [NREGS-1:0] v);
        logic [ADDR_W:0] cnt;
        cnt = {(ADDR_W+1){1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Writeback qualifies only against the pre-edge scoreboard entry; r0 is never a target.
    always_comb begin
        wb_hit_s    = wb_valid && (wb_addr != {ADDR_W{1'b0}}) &&
                      busy_q[wb_addr] && (tag_q[wb_addr] == wb_tag);
        alloc_hit_s = alloc_valid && (alloc_addr != {ADDR_W{1'b0}}) && !flush;
    end

    // Next-state scoreboard: writeback commits data, flush clears busy, alloc wins over both.
    always_comb begin
        busy_d   = busy_q;
        wb_sel_s = {NREGS{1'b0}};
        al_sel_s = {NREGS{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            wb_sel_s[i] = wb_hit_s && (wb_addr == ADDR_W'(i));
            al_sel_s[i] = alloc_hit_s && (alloc_addr == ADDR_W'(i));
            data_d[i]   = wb_sel_s[i] ? wb_data : data_q[i];
            tag_d[i]    = al_sel_s[i] ? alloc_tag : tag_q[i];
            busy_d[i]   = al_sel_s[i] | (busy_q[i] & ~wb_sel_s[i] & ~flush);
        end
        busy_cnt_d = popcount(busy_d);
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                data_q[i] <= {DATA_W{1'b0}};
                tag_q[i]  <= {TAG_W{1'b0}};
            end
            busy_q     <= {NREGS{1'b0}};
            busy_cnt_q <= {(ADDR_W+1){1'b0}};
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                data_q[i] <= data_d[i];
                tag_q[i]  <= tag_d[i];
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Unpack the read address bus.
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            raddr_s[k] = raddr[k*ADDR_W +: ADDR_W];
        end
    end

    // Read ports: same-cycle qualifying writeback bypasses; a same-cycle alloc stays invisible.
    always_comb begin
        rdata = {(NRD*DATA_W){1'b0}};
        rbusy = {NRD{1'b0}};
        rtag  = {(NRD*TAG_W){1'b0}};
        for (int k = 0; k < NRD; k++) begin
            if (rst && rena[k] && (raddr_s[k] != {ADDR_W{1'b0}})) begin
                if (wb_hit_s && (wb_addr == raddr_s[k])) begin
                    rdata[k*DATA_W +: DATA_W] = wb_data;
                    rbusy[k]                  = 1'b0;
                    rtag[k*TAG_W +: TAG_W]    = {TAG_W{1'b0}};
                end else if (busy_q[raddr_s[k]]) begin
                    rdata[k*DATA_W +: DATA_W] = data_q[raddr_s[k]];
                    rbusy[k]                  = 1'b1;
                    rtag[k*TAG_W +: TAG_W]    = tag_q[raddr_s[k]];
                end else begin
                    rdata[k*DATA_W +: DATA_W] = data_q[raddr_s[k]];
                    rbusy[k]                  = 1'b0;
                    rtag[k*TAG_W +: TAG_W]    = {TAG_W{1'b0}};
                end
            end else begin
                rdata[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                rbusy[k]                  = 1'b0;
                rtag[k*TAG_W +: TAG_W]    = {TAG_W{1'b0}};
            end
        end
    end

    // Debug port shows raw storage only; held at zero during reset.
    always_comb begin
        if (rst) begin
            dbg_data = data_q[dbg_addr];
        end else begin
            dbg_data = {DATA_W{1'b0}};
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_tagged.sv
// Directed and randomized bench for regfile_tagged against a scoreboard-level reference model.
module tb_regfile_tagged;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int TW  = 4;
    localparam int NRD = 2;
    localparam int NR  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRD-1:0]    rena;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata;
    logic [NRD-1:0]    rbusy;
    logic [NRD*TW-1:0] rtag;
    logic              alloc_valid;
    logic [AW-1:0]     alloc_addr;
    logic [TW-1:0]     alloc_tag;
    logic              wb_valid;
    logic [AW-1:0]     wb_addr;
    logic [TW-1:0]     wb_tag;
    logic [DW-1:0]     wb_data;
    logic              flush;
    logic [AW-1:0]     dbg_addr;
    logic [DW-1:0]     dbg_data;
    logic [AW:0]       busy_cnt;

    int checks = 0;
    int passed = 0;

    logic [DW-1:0] m_data [NR];
    logic          m_busy [NR];
    logic [TW-1:0] m_tag  [NR];

    regfile_tagged #(.DATA_W(DW), .ADDR_W(AW), .TAG_W(TW), .NRD(NRD)) dut (
        .clk(clk), .rst(rst), .rena(rena), .raddr(raddr), .rdata(rdata),
        .rbusy(rbusy), .rtag(rtag), .alloc_valid(alloc_valid),
        .alloc_addr(alloc_addr), .alloc_tag(alloc_tag), .wb_valid(wb_valid),
        .wb_addr(wb_addr), .wb_tag(wb_tag), .wb_data(wb_data), .flush(flush),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < NR; i++) n += m_busy[i] ? 1 : 0;
        return n;
    endfunction

    function automatic bit wb_qualifies();
        return wb_valid && (wb_addr != 0) && m_busy[wb_addr] && (m_tag[wb_addr] == wb_tag);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_data[i] = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    task automatic check_reads();
        for (int k = 0; k < NRD; k++) begin
            int a;
            logic [DW-1:0] ed;
            logic eb;
            logic [TW-1:0] et;
            a = int'(raddr[k*AW +: AW]);
            ed = '0; eb = 1'b0; et = '0;
            if (rena[k] && a != 0) begin
                if (wb_qualifies() && int'(wb_addr) == a) ed = wb_data;
                else begin
                    ed = m_data[a];
                    eb = m_busy[a];
                    et = m_busy[a] ? m_tag[a] : '0;
                end
            end
            check($sformatf("rdata%0d", k), 64'(rdata[k*DW +: DW]), 64'(ed));
            check($sformatf("rbusy%0d", k), 64'(rbusy[k]), 64'(eb));
            check($sformatf("rtag%0d", k), 64'(rtag[k*TW +: TW]), 64'(et));
        end
        check("dbg_data", 64'(dbg_data), 64'(m_data[dbg_addr]));
    endtask

    task automatic model_step();
        bit q;
        q = wb_qualifies();
        if (q) begin
            m_data[wb_addr] = wb_data;
            m_busy[wb_addr] = 1'b0;
        end
        if (flush) begin
            for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        end else if (alloc_valid && alloc_addr != 0) begin
            m_busy[alloc_addr] = 1'b1;
            m_tag[alloc_addr]  = alloc_tag;
        end
    endtask

    // Inputs are set at posedge+1; reads are checked at +3, the model advances on the edge.
    task automatic do_cycle();
        #2;
        check_reads();
        @(posedge clk);
        model_step();
        #1;
        check("busy_cnt", 64'(busy_cnt), 64'(model_count()));
        alloc_valid = 1'b0;
        wb_valid    = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic read2(input int a0, input int a1);
        rena  = 2'b11;
        raddr = {AW'(a1), AW'(a0)};
    endtask

    task automatic do_alloc(input int a, input int t);
        alloc_valid = 1'b1;
        alloc_addr  = AW'(a);
        alloc_tag   = TW'(t);
    endtask

    task automatic do_wb(input int a, input int t, input logic [DW-1:0] d);
        wb_valid = 1'b1;
        wb_addr  = AW'(a);
        wb_tag   = TW'(t);
        wb_data  = d;
    endtask

    task automatic random_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            int wa;
            rena = NRD'($urandom);
            if ($urandom_range(0, 3) == 0) do_alloc($urandom_range(0, 9), $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                wa = $urandom_range(0, 9);
                do_wb(wa, ($urandom_range(0, 2) != 0) ? int'(m_tag[wa]) : $urandom_range(0, 15), $urandom);
            end
            flush    = ($urandom_range(0, 15) == 0);
            raddr    = {AW'($urandom_range(0, 9)), ($urandom_range(0, 1) == 1) ? wb_addr : AW'($urandom_range(0, 31))};
            dbg_addr = AW'($urandom_range(0, 9));
            do_cycle();
        end
    endtask

    initial begin
        rst = 1'b0; rena = '0; raddr = '0; alloc_valid = 1'b0; alloc_addr = '0;
        alloc_tag = '0; wb_valid = 1'b0; wb_addr = '0; wb_tag = '0; wb_data = '0;
        flush = 1'b0; dbg_addr = '0;
        model_clear();
        #2;
        check("reset_busy_cnt", 64'(busy_cnt), 64'd0);
        check("reset_rdata", 64'(rdata), 64'd0);
        #10;
        rst = 1'b1;

        read2(5, 5);
        do_cycle();
        check("r5_initial", 64'(rdata[DW-1:0]), 64'd0);
        do_alloc(5, 3);
        do_cycle();
        #1;
        check("r5_busy", 64'(rbusy), 64'b11);
        check("r5_tag", 64'(rtag[TW-1:0]), 64'd3);
        check("cnt_after_alloc", 64'(busy_cnt), 64'd1);

        do_wb(5, 3, 32'hDEADBEEF);
        #1;
        check("bypass_data", 64'(rdata[DW-1:0]), 64'hDEADBEEF);
        check("bypass_busy", 64'(rbusy), 64'b00);
        do_cycle();
        #1;
        check("r5_held", 64'(rdata[2*DW-1:DW]), 64'hDEADBEEF);
        check("cnt_after_wb", 64'(busy_cnt), 64'd0);

        read2(7, 7);
        dbg_addr = AW'(7);
        do_alloc(7, 1);         do_cycle();
        do_alloc(7, 2);         do_cycle();
        do_wb(7, 1, 32'h11);    do_cycle();
        #1;
        check("stale_busy", 64'(rbusy[0]), 64'd1);
        check("stale_tag", 64'(rtag[TW-1:0]), 64'd2);
        do_wb(7, 2, 32'h22);    do_cycle();
        #1;
        check("r7_data", 64'(dbg_data), 64'h22);

        read2(9, 9);
        dbg_addr = AW'(9);
        do_alloc(9, 4);         do_cycle();
        do_alloc(9, 6);
        do_wb(9, 4, 32'h55);    do_cycle();
        #1;
        check("r9_data", 64'(dbg_data), 64'h55);
        check("r9_busy", 64'(rbusy[0]), 64'd1);
        check("r9_tag", 64'(rtag[TW-1:0]), 64'd6);

        read2(1, 4);
        for (int i = 1; i <= 3; i++) begin
            do_alloc(i, i);
            do_cycle();
        end
        do_alloc(4, 5);
        flush = 1'b1;
        do_cycle();
        #1;
        check("flush_cnt", 64'(busy_cnt), 64'd0);
        check("flush_r4", 64'(rbusy[1]), 64'd0);

        read2(0, 0);
        dbg_addr = AW'(0);
        do_alloc(0, 7);
        do_wb(0, 7, 32'hFFFFFFFF);
        do_cycle();
        #1;
        check("r0_data", 64'(rdata), 64'd0);
        check("r0_dbg", 64'(dbg_data), 64'd0);

        random_cycles(300);

        do_alloc(3, 9); do_cycle();
        read2(3, 9);
        dbg_addr = AW'(9);
        do_wb(9, 6, 32'h77);
        #2;
        rst = 1'b0;
        #1;
        check("async_rdata", 64'(rdata), 64'd0);
        check("async_rbusy", 64'(rbusy), 64'd0);
        check("async_rtag", 64'(rtag), 64'd0);
        check("async_dbg", 64'(dbg_data), 64'd0);
        check("async_cnt", 64'(busy_cnt), 64'd0);
        model_clear();
        wb_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        random_cycles(300);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_tagged.md
Name: regfile_tagged

Overview:
- Parametrised successor to the scalar two-read-port register file, for the dynamic-pipeline core.
- Adds NRD read ports, a per-register busy/tag scoreboard written at dispatch, and tag-qualified writeback from the common data bus.
- Adds a global flush on mispredict/exception, a busy-register counter and a debug read port.
- Sits between dispatch, which reads operands and allocates destinations, and the CDB, which carries writebacks.

Parameters:
- DATA_W, 32, data width of each register.
- ADDR_W, 5, register address width; register count NREGS = 2**ADDR_W.
- TAG_W, 4, width of the producer tag (ROB/RS index).
- NRD, 2, number of read ports; range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rena  in  NRD  per-port read enable.
- raddr  in  NRD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rdata  out  NRD*DATA_W  read data, same packing as raddr.
- rbusy  out  NRD  operand not yet produced.
- rtag  out  NRD*TAG_W  producer tag; valid only when rbusy=1.
- alloc_valid  in  1  dispatch claims a destination register.
- alloc_addr  in  ADDR_W  destination register being claimed.
- alloc_tag  in  TAG_W  tag of the new producer.
- wb_valid  in  1  CDB writeback valid.
- wb_addr  in  ADDR_W  writeback destination.
- wb_tag  in  TAG_W  tag of the writing producer.
- wb_data  in  DATA_W  writeback data.
- flush  in  1  clear all busy bits.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  raw register contents, no bypass.
- busy_cnt  out  ADDR_W+1  number of busy registers, registered.

Behaviour:
- State per register: data[DATA_W], busy, tag[TAG_W].
- Reset (rst=0, asynchronous): all data, busy and tag cleared to 0; busy_cnt=0.
- While rst=0, rdata, rbusy, rtag and dbg_data are forced to 0.
- Register 0:
  - Always reads data 0 and busy 0.
  - Allocations to it are ignored.
  - Writebacks to it are discarded.
- Writeback (edge):
  - Condition: wb_valid=1, wb_addr!=0, busy[wb_addr]=1 and tag[wb_addr]==wb_tag.
  - Effect: data[wb_addr]<=wb_data and busy cleared.
  - Tag mismatch or register not busy: stale writeback; no state change.
- Allocate (edge): when alloc_valid=1 and alloc_addr!=0, busy[alloc_addr]<=1 and tag[alloc_addr]<=alloc_tag.
- Alloc and wb to the same register in the same cycle:
  - The writeback data is committed if it matches the OLD tag.
  - busy stays 1 and tag becomes alloc_tag; the allocation wins.
- Flush (edge):
  - Every busy bit cleared; data and tag are retained.
  - flush has priority over alloc: an alloc in the flush cycle is dropped.
  - A writeback in the flush cycle still commits data if it matches the pre-flush tag.
- Read port k (combinational, ports are independent):
  - rena[k]=0 or raddr_k=0: rdata=0, rbusy=0, rtag=0.
  - Bypass: if a qualifying writeback targets raddr_k in the same cycle, rdata=wb_data, rbusy=0, rtag=0.
  - Otherwise, if busy: rdata=data, rbusy=1, rtag=tag.
  - Otherwise: rdata=data, rbusy=0, rtag=0.
  - A same-cycle alloc is not visible until the next cycle; reads see the pre-alloc state.
- dbg_data = data[dbg_addr] combinationally; no bypass, ignores busy.
- busy_cnt:
  - Registered each cycle as the population count of busy bits after the edge's update.
  - Equals 0 in the cycle after a flush.
  - Never exceeds NREGS-1.
- Re-allocating an already-busy register overwrites its tag; busy_cnt is unchanged.

Test Plan:
- Reset, then read r5 on both ports -> rdata=0, rbusy=0, busy_cnt=0; then alloc r5 tag 3 -> next cycle rbusy=1, rtag=3, busy_cnt=1.
- r5 busy with tag 3; wb r5 tag 3 data 0xDEADBEEF, read r5 in the same cycle -> rdata=0xDEADBEEF, rbusy=0 (bypass); next cycle data held, busy_cnt=0.
- Alloc r7 tag 1, then re-alloc r7 tag 2, then wb r7 tag 1 data 0x11 -> discarded, r7 still busy with tag 2; then wb tag 2 data 0x22 -> r7=0x22, not busy.
- Same-cycle alloc r9 tag 6 and wb r9 (old tag 4) data 0x55 -> r9 data=0x55, busy=1, tag=6.
- Alloc r1..r3, then flush together with alloc r4 -> busy_cnt=0, r4 not busy, data in r1..r3 unchanged.
- Alloc/wb to r0 with data 0xFFFFFFFF -> reads 0, busy 0. Assert rst low mid-sequence -> all outputs 0 immediately, without waiting for a clock edge.
